// File: rtl/case_gate_pkg.sv
// Shared types and constants for the 4-input gate truth-table sweeper.
package case_gate_pkg;

    // Number of input vectors for a 4-input gate.
    localparam int unsigned NVEC = 16;

    // Reference truth table of the gate under control: F = ~(C & D).
    localparam logic [15:0] GATE_EXPECTED = 16'h7777;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSample,
        StFin
    } state_e;

endpackage

// File: rtl/case_gate_settle_cnt.sv
// 4-bit settle down-counter: loaded on entry to WAIT, counts down to zero.
module case_gate_settle_cnt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;

    // Load takes priority over decrement; the count saturates at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Zero flag tells the sweeper the final WAIT cycle has been reached.
    always_comb begin
        zero_o = (cnt_q == 4'd0);
    end

endmodule

// File: rtl/case_gate_sweeper.sv
// Sweeps all 16 input vectors of an external 4-input gate, captures F per
// vector, and compares against an expected truth table latched at START.
module case_gate_sweeper
    import case_gate_pkg::*;
#(
    // Cycles each vector is held before F is sampled; legal range 1..15.
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] exp_i,
    input  logic        f_i,
    output logic        a_o,
    output logic        b_o,
    output logic        c_o,
    output logic        d_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] table_o,
    output logic [4:0]  mismatch_o,
    output logic [3:0]  first_fail_o,
    output logic        pass_o
);

    // The counter reaches zero on the last WAIT cycle, so load SETTLE-1.
    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);
    localparam logic [3:0] LastVec    = 4'(NVEC - 1);

    state_e      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  mismatch_q, mismatch_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [3:0]  abcd_q, abcd_d;

    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;

    case_gate_settle_cnt u_settle_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (SettleLoad),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // State and result registers; synchronous reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            vec_q        <= 4'd0;
            exp_q        <= 16'h0000;
            table_q      <= 16'h0000;
            mismatch_q   <= 5'd0;
            first_fail_q <= 4'd0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            abcd_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            exp_q        <= exp_d;
            table_q      <= table_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            abcd_q       <= abcd_d;
        end
    end

    // Next-state, result updates and registered gate drive.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        exp_d        = exp_q;
        table_d      = table_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    exp_d        = exp_i;
                    vec_d        = 4'd0;
                    table_d      = 16'h0000;
                    mismatch_d   = 5'd0;
                    first_fail_d = 4'd0;
                    pass_d       = 1'b0;
                    cnt_load     = 1'b1;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    state_d = StSample;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StSample: begin
                // Abort wins: the in-flight sample is dropped.
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    table_d[vec_q] = f_i;
                    if (f_i != exp_q[vec_q]) begin
                        mismatch_d = mismatch_q + 5'd1;
                        if (mismatch_q == 5'd0) begin
                            first_fail_d = vec_q;
                        end
                    end
                    if (vec_q == LastVec) begin
                        state_d = StFin;
                    end else begin
                        vec_d    = vec_q + 4'd1;
                        cnt_load = 1'b1;
                        state_d  = StWait;
                    end
                end
            end
            StFin: begin
                done_d  = 1'b1;
                pass_d  = (mismatch_q == 5'd0);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they change on the edge.
        busy_d = (state_d == StWait) || (state_d == StSample);
        abcd_d = busy_d ? vec_d : 4'd0;
    end

    // Output mapping.
    always_comb begin
        a_o          = abcd_q[3];
        b_o          = abcd_q[2];
        c_o          = abcd_q[1];
        d_o          = abcd_q[0];
        busy_o       = busy_q;
        done_o       = done_q;
        table_o      = table_q;
        mismatch_o   = mismatch_q;
        first_fail_o = first_fail_q;
        pass_o       = pass_q;
    end

endmodule

// File: doc/case_gate_sweeper.md
CASE_GATE_SWEEPER -- requirements
Module: case_gate_sweeper

Interface
REQ-001 Parameter SETTLE, 1, cycles the inputs are held before F is sampled; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  sweep request; sampled only in IDLE.
REQ-005 ABORT  input  1  terminates a running sweep.
REQ-006 EXP  input  16  expected truth table; bit index = {A,B,C,D}; latched when START is accepted.
REQ-007 F  input  1  output of the external 4-input gate under control.
REQ-008 A, B, C, D  output  1 each  registered drive to the gate inputs.
REQ-009 BUSY  output  1  high in WAIT and SAMPLE.
REQ-010 DONE  output  1  one-cycle pulse on sweep completion.
REQ-011 TABLE  output  16  captured F value per vector.
REQ-012 MISMATCH  output  5  count of vectors with F != EXP bit; range 0..16.
REQ-013 FIRST_FAIL  output  4  lowest vector index that mismatched.
REQ-014 PASS  output  1  high when the last completed sweep had MISMATCH == 0.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, SAMPLE and FIN.
REQ-016 IDLE with START=1 SHALL latch EXP, set vec=0, clear TABLE, MISMATCH, FIRST_FAIL and PASS, and enter WAIT.
REQ-017 {A,B,C,D} SHALL equal vec whenever BUSY=1, and 4'b0000 otherwise.
REQ-018 WAIT SHALL last exactly SETTLE cycles, then enter SAMPLE.
REQ-019 SAMPLE (1 cycle) SHALL write TABLE[vec]=F and increment MISMATCH when F != EXP_latched[vec].
REQ-020 On the first mismatch of a sweep, SAMPLE SHALL load FIRST_FAIL=vec; later mismatches leave it unchanged.
REQ-021 SAMPLE with vec<15 SHALL increment vec and return to WAIT.
REQ-022 SAMPLE with vec=15 SHALL enter FIN; vec SHALL NOT wrap.
REQ-023 FIN SHALL assert DONE for exactly one cycle, load PASS=(MISMATCH==0), and return to IDLE.
REQ-024 Latency: DONE SHALL assert 16*(SETTLE+1)+1 cycles after the edge that accepted START (33 cycles at SETTLE=1).
REQ-025 START SHALL be ignored in WAIT, SAMPLE and FIN.
REQ-026 START held high through FIN SHALL be accepted in the following IDLE cycle.
REQ-027 ABORT in WAIT or SAMPLE SHALL force IDLE on the next edge with no DONE pulse and PASS=0.
REQ-028 After ABORT, TABLE, MISMATCH and FIRST_FAIL SHALL hold their partial values.
REQ-029 On a SAMPLE cycle with ABORT=1, the sample SHALL NOT be recorded; ABORT has priority.
REQ-030 ABORT in IDLE or FIN SHALL have no effect.
REQ-031 Result outputs SHALL hold until the next accepted START or RST.
REQ-032 FIRST_FAIL is meaningful only when MISMATCH != 0.

Reset
REQ-033 RST SHALL take priority over START and ABORT in every state, including mid-sweep.
REQ-034 On RST: state=IDLE, vec=0, A=B=C=D=0, BUSY=0, DONE=0, TABLE=16'h0000, MISMATCH=0, FIRST_FAIL=0, PASS=0.

Structure
REQ-035 Package case_gate_pkg SHALL hold:
- the state enum;
- NVEC=16;
- GATE_EXPECTED=16'h7777 (zeros at vectors 3, 7, 11, 15).
REQ-036 The sweeper SHALL NOT instantiate the gate; the gate is external.
REQ-037 Optional sub-module: case_gate_settle_cnt, a 4-bit down-counter with load and zero flag.

Verification
REQ-038 SETTLE=1, gate attached, EXP=16'h7777, START -> DONE at cycle 33; TABLE=16'h7777, MISMATCH=0, PASS=1.
REQ-039 EXP=16'hFFFF -> MISMATCH=4, FIRST_FAIL=3, PASS=0, TABLE=16'h7777.
REQ-040 ABORT while vec=5 -> BUSY=0 and ABCD=0000 next cycle; no DONE; MISMATCH frozen; PASS=0.
REQ-041 START pulsed during BUSY -> ignored; START held high -> new sweep begins in the IDLE cycle after FIN.
REQ-042 RST asserted at vec=9 -> all outputs at reset values on the next edge; a new START completes normally.
REQ-043 SETTLE=3 -> each vector held 3 cycles; DONE at cycle 65.
